// File: rtl/crc_uart_pkg.sv
// Shared types and constants for the UART / checksum frame controller.
package crc_uart_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OVERRUN = 2'b01,
    ERR_BYTE_TO = 2'b10,
    ERR_CRC_TO  = 2'b11
  } err_e;

  localparam logic [16:0] DEFAULT_POLY = 17'h11021;

endpackage

// File: rtl/crc_byte_sender.sv
// Two-byte valid/ready serializer: returns a 16-bit CRC high byte first.
module crc_byte_sender (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] crc_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        hi_ack_o,
  output logic        lo_ack_o,
  output logic        frame_done_o
);

  logic       valid_r;
  logic       lo_phase_r;
  logic       done_r;
  logic [7:0] data_r;
  logic [7:0] lo_byte_r;
  logic       hs_s;

  assign hs_s         = valid_r & tx_ready_i;
  assign hi_ack_o     = hs_s & ~lo_phase_r;
  assign lo_ack_o     = hs_s & lo_phase_r;
  assign tx_data_o    = data_r;
  assign tx_valid_o   = valid_r;
  assign frame_done_o = done_r;

  // Output byte register; data only moves on a handshake, so it is stable under back-pressure
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r    <= 1'b0;
      lo_phase_r <= 1'b0;
      done_r     <= 1'b0;
      data_r     <= 8'h00;
      lo_byte_r  <= 8'h00;
    end else begin
      done_r <= lo_ack_o;
      if (start_i) begin
        valid_r    <= 1'b1;
        lo_phase_r <= 1'b0;
        data_r     <= crc_i[15:8];
        lo_byte_r  <= crc_i[7:0];
      end else if (hi_ack_o) begin
        lo_phase_r <= 1'b1;
        data_r     <= lo_byte_r;
      end else if (lo_ack_o) begin
        valid_r    <= 1'b0;
        lo_phase_r <= 1'b0;
        data_r     <= 8'h00;
      end
    end
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame controller: packs UART bytes for the checksum engine and returns its CRC.
module crc_frame_ctrl
  import crc_uart_pkg::*;
#(
  parameter int unsigned NBYTES  = 5,
  parameter logic [16:0] POLY    = DEFAULT_POLY,
  parameter int unsigned BYTE_TO = 1023,
  parameter int unsigned CRC_TO  = 63
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [8*NBYTES-1:0]   crc_data_o,
  output logic                  crc_we_o,
  output logic [16:0]           crc_mask_o,
  input  logic [15:0]           crc_i,
  input  logic                  crc_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [1:0]            err_o
);

  localparam int unsigned DATA_W = 8 * NBYTES;
  localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;
  localparam int unsigned IDLE_W = $clog2(BYTE_TO) + 1;
  localparam int unsigned WAIT_W = $clog2(CRC_TO) + 1;

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [IDLE_W-1:0]   idle_r, idle_s;
  logic [WAIT_W-1:0]   wait_r, wait_s;
  // Holds the first NBYTES-1 bytes; the last byte goes straight into the load word
  logic [DATA_W-9:0]   buf_r, buf_s;
  logic [DATA_W-1:0]   crc_data_r;
  logic                crc_we_r, we_s;
  err_e                err_r, fsm_err_s, err_next_s;
  logic                busy_r;
  logic                start_s;
  logic                hi_ack_s, lo_ack_s;

  // Next-state, counters and error detection
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idle_s    = idle_r;
    wait_s    = wait_r;
    buf_s     = buf_r;
    fsm_err_s = ERR_NONE;
    we_s      = 1'b0;
    start_s   = 1'b0;
    case (state_r)
      COLLECT: begin
        if (rx_valid_i) begin
          idle_s = '0;
          if (cnt_r == CNT_W'(NBYTES - 1)) begin
            cnt_s   = '0;
            we_s    = 1'b1;
            state_s = LOAD;
          end else begin
            buf_s[(DATA_W - 9) - 8 * int'(cnt_r) -: 8] = rx_data_i;
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else if (cnt_r != '0) begin
          if (idle_r == IDLE_W'(BYTE_TO - 1)) begin
            fsm_err_s = ERR_BYTE_TO;
            cnt_s     = '0;
            idle_s    = '0;
          end else begin
            idle_s = idle_r + IDLE_W'(1);
          end
        end else begin
          idle_s = '0;
        end
      end
      LOAD: begin
        wait_s  = WAIT_W'(1);
        state_s = WAIT;
      end
      WAIT: begin
        // wait_r equals the number of cycles since LOAD; a result on the last cycle still wins
        if (crc_valid_i) begin
          start_s = 1'b1;
          state_s = SEND_HI;
        end else if (wait_r == WAIT_W'(CRC_TO - 1)) begin
          fsm_err_s = ERR_CRC_TO;
          cnt_s     = '0;
          state_s   = COLLECT;
        end else begin
          wait_s = wait_r + WAIT_W'(1);
        end
      end
      SEND_HI: begin
        if (hi_ack_s) begin
          state_s = SEND_LO;
        end else begin
          state_s = SEND_HI;
        end
      end
      SEND_LO: begin
        if (lo_ack_s) begin
          state_s = COLLECT;
        end else begin
          state_s = SEND_LO;
        end
      end
      default: begin
        state_s = COLLECT;
        cnt_s   = '0;
      end
    endcase
  end

  assign err_next_s = (fsm_err_s == ERR_NONE && rx_valid_i && state_r != COLLECT)
                      ? ERR_OVERRUN : fsm_err_s;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= COLLECT;
      cnt_r      <= '0;
      idle_r     <= '0;
      wait_r     <= '0;
      buf_r      <= '0;
      crc_data_r <= '0;
      crc_we_r   <= 1'b0;
      err_r      <= ERR_NONE;
      busy_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idle_r   <= idle_s;
      wait_r   <= wait_s;
      buf_r    <= buf_s;
      crc_we_r <= we_s;
      err_r    <= err_next_s;
      busy_r   <= (state_s != COLLECT);
      if (we_s) begin
        crc_data_r <= {buf_r, rx_data_i};
      end
    end
  end

  crc_byte_sender u_sender (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_s),
    .crc_i        (crc_i),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .hi_ack_o     (hi_ack_s),
    .lo_ack_o     (lo_ack_s),
    .frame_done_o (frame_done_o)
  );

  assign crc_data_o = crc_data_r;
  assign crc_we_o   = crc_we_r;
  assign crc_mask_o = POLY;
  assign busy_o     = busy_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Directed bench for crc_frame_ctrl with a fixed-latency checksum engine stub.
module tb_crc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [39:0] crc_data;
  logic        crc_we;
  logic [16:0] crc_mask;
  logic [15:0] crc;
  logic        crc_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic [1:0]  err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // monitor state (written only by the monitor process)
  int cyc = 0;
  int we_cnt = 0, done_cnt = 0, ovr_cnt = 0, bto_cnt = 0, cto_cnt = 0;
  int last_rx_cyc = 0, last_we_cyc = 0, last_bto_cyc = 0, last_cto_cyc = 0;
  int cv_rise_cyc = 0, txv_rise_cyc = 0;
  logic cv_prev = 1'b0, txv_prev = 1'b0;
  logic [7:0] tx_q[$];

  // stub engine
  logic stub_en;
  logic stub_run;
  int   stub_cnt;

  always #5 clk = ~clk;

  crc_frame_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .crc_data_o   (crc_data),
    .crc_we_o     (crc_we),
    .crc_mask_o   (crc_mask),
    .crc_i        (crc),
    .crc_valid_i  (crc_valid),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .err_o        (err)
  );

  assign crc = 16'hBEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_valid <= 1'b0;
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
    end else if (crc_we) begin
      crc_valid <= 1'b0;
      stub_run  <= 1'b1;
      stub_cnt  <= 1;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == 41) begin
        crc_valid <= stub_en;
        stub_run  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid) last_rx_cyc = cyc;
    if (crc_we) begin we_cnt++; last_we_cyc = cyc; end
    if (frame_done) done_cnt++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (err == 2'b01) ovr_cnt++;
    if (err == 2'b10) begin bto_cnt++; last_bto_cyc = cyc; end
    if (err == 2'b11) begin cto_cnt++; last_cto_cyc = cyc; end
    if (crc_valid && !cv_prev) cv_rise_cyc = cyc;
    if (tx_valid && !txv_prev) txv_rise_cyc = cyc;
    cv_prev  = crc_valid;
    txv_prev = tx_valid;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39 - 8 * i -: 8]);
  endtask

  task automatic wait_done(input string name, input int snap);
    int n;
    n = 0;
    while (done_cnt == snap && n < 300) begin tick(); n++; end
    total_cnt++;
    if (done_cnt == snap) $display("FAIL %s: frame_done timeout, got %0d pulses, expected 1", name, done_cnt - snap);
    else pass_cnt++;
    tick();
  endtask

  task automatic wait_tx_valid(input string name);
    int n;
    n = 0;
    while (!tx_valid && n < 200) begin tick(); n++; end
    total_cnt++;
    if (!tx_valid) $display("FAIL %s: tx_valid never rose, got 0 expected 1", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; stub_en = 1'b1;
    repeat (3) tick();
    total_cnt += 8;
    if (crc_data !== 40'h0) $display("FAIL rst_crc_data: got %h expected 0", crc_data); else pass_cnt++;
    if (crc_we !== 1'b0) $display("FAIL rst_crc_we: got %b expected 0", crc_we); else pass_cnt++;
    if (crc_mask !== 17'h11021) $display("FAIL rst_mask: got %h expected 11021", crc_mask); else pass_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); else pass_cnt++;
    if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h expected 00", tx_data); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", frame_done); else pass_cnt++;
    if (err !== 2'b00) $display("FAIL rst_err: got %b expected 00", err); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_frame();
    int we0, d0, q0;
    we0 = we_cnt; d0 = done_cnt; q0 = tx_q.size();
    send_frame(40'h3132333435);
    wait_done("frame_done", d0);
    total_cnt += 8;
    if (crc_data !== 40'h3132333435) $display("FAIL frame_data: got %h expected 3132333435", crc_data); else pass_cnt++;
    if (we_cnt - we0 !== 1) $display("FAIL frame_we: got %0d pulses expected 1", we_cnt - we0); else pass_cnt++;
    if (last_we_cyc - last_rx_cyc !== 1) $display("FAIL frame_we_lat: got %0d expected 1", last_we_cyc - last_rx_cyc); else pass_cnt++;
    if (txv_rise_cyc - cv_rise_cyc !== 1) $display("FAIL frame_tx_lat: got %0d expected 1", txv_rise_cyc - cv_rise_cyc); else pass_cnt++;
    if (tx_q.size() - q0 !== 2) $display("FAIL frame_tx_count: got %0d expected 2", tx_q.size() - q0); else pass_cnt++;
    if (tx_q[q0] !== 8'hBE) $display("FAIL frame_tx_hi: got %h expected BE", tx_q[q0]); else pass_cnt++;
    if (tx_q[q0 + 1] !== 8'hEF) $display("FAIL frame_tx_lo: got %h expected EF", tx_q[q0 + 1]); else pass_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int d0, q0;
    d0 = done_cnt; q0 = tx_q.size();
    tx_ready = 1'b0;
    send_frame(40'h4142434445);
    wait_tx_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hBE)
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=BE", i, tx_valid, tx_data);
      else pass_cnt++;
      tick();
    end
    tx_ready = 1'b1;
    wait_done("bp_done", d0);
    total_cnt += 4;
    if (crc_data !== 40'h4142434445) $display("FAIL bp_data: got %h expected 4142434445", crc_data); else pass_cnt++;
    if (tx_q.size() - q0 !== 2) $display("FAIL bp_tx_count: got %0d expected 2", tx_q.size() - q0); else pass_cnt++;
    if (tx_q[q0] !== 8'hBE) $display("FAIL bp_tx_hi: got %h expected BE", tx_q[q0]); else pass_cnt++;
    if (tx_q[q0 + 1] !== 8'hEF) $display("FAIL bp_tx_lo: got %h expected EF", tx_q[q0 + 1]); else pass_cnt++;
  endtask

  task automatic test_byte_timeout();
    int b0, d0;
    b0 = bto_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    repeat (1100) tick();
    total_cnt += 2;
    if (bto_cnt - b0 !== 1) $display("FAIL bto_count: got %0d expected 1", bto_cnt - b0); else pass_cnt++;
    if (last_bto_cyc - last_rx_cyc !== 1024) $display("FAIL bto_delay: got %0d expected 1024", last_bto_cyc - last_rx_cyc); else pass_cnt++;
    d0 = done_cnt;
    send_frame(40'h5152535455);
    wait_done("bto_next_done", d0);
    total_cnt++;
    if (crc_data !== 40'h5152535455) $display("FAIL bto_next_data: got %h expected 5152535455", crc_data); else pass_cnt++;
    // last byte lands on the cycle the timeout would expire
    b0 = bto_cnt; d0 = done_cnt;
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_byte(8'h64);
    repeat (1022) tick();
    send_byte(8'h65);
    wait_done("bto_edge_done", d0);
    total_cnt += 2;
    if (bto_cnt - b0 !== 0) $display("FAIL bto_edge_err: got %0d timeouts expected 0", bto_cnt - b0); else pass_cnt++;
    if (crc_data !== 40'h6162636465) $display("FAIL bto_edge_data: got %h expected 6162636465", crc_data); else pass_cnt++;
  endtask

  task automatic test_overrun();
    int o0, d0, q0;
    o0 = ovr_cnt; d0 = done_cnt; q0 = tx_q.size();
    send_frame(40'h7172737475);
    repeat (3) tick();
    send_byte(8'hAA);
    repeat (2) tick();
    total_cnt++;
    if (ovr_cnt - o0 !== 1) $display("FAIL ovr_count: got %0d expected 1", ovr_cnt - o0); else pass_cnt++;
    wait_done("ovr_done", d0);
    total_cnt += 2;
    if (tx_q.size() - q0 !== 2 || tx_q[q0] !== 8'hBE || tx_q[q0 + 1] !== 8'hEF)
      $display("FAIL ovr_tx: got %0d bytes first=%h expected 2 bytes BE EF", tx_q.size() - q0, tx_q[q0]);
    else pass_cnt++;
    if (crc_data !== 40'h7172737475) $display("FAIL ovr_data: got %h expected 7172737475", crc_data); else pass_cnt++;
    d0 = done_cnt;
    send_frame(40'h8182838485);
    wait_done("ovr_next_done", d0);
    total_cnt++;
    if (crc_data !== 40'h8182838485) $display("FAIL ovr_next_data: got %h expected 8182838485", crc_data); else pass_cnt++;
  endtask

  task automatic test_crc_timeout();
    int c0, d0;
    c0 = cto_cnt;
    stub_en = 1'b0;
    send_frame(40'h9192939495);
    repeat (80) tick();
    total_cnt += 3;
    if (cto_cnt - c0 !== 1) $display("FAIL cto_count: got %0d expected 1", cto_cnt - c0); else pass_cnt++;
    if (last_cto_cyc - last_we_cyc !== 63) $display("FAIL cto_delay: got %0d expected 63", last_cto_cyc - last_we_cyc); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL cto_busy: got %b expected 0", busy); else pass_cnt++;
    stub_en = 1'b1;
    d0 = done_cnt;
    send_frame(40'h1112131415);
    wait_done("cto_next_done", d0);
  endtask

  task automatic test_reset_in_send_lo();
    int d0, q0;
    tx_ready = 1'b0;
    send_frame(40'h2122232425);
    wait_tx_valid("rsl_valid");
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEF)
      $display("FAIL rsl_lo: got valid=%b data=%h expected valid=1 data=EF", tx_valid, tx_data);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt += 2;
    if (tx_valid !== 1'b0) $display("FAIL rsl_tx_valid: got %b expected 0", tx_valid); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL rsl_busy: got %b expected 0", busy); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    d0 = done_cnt; q0 = tx_q.size();
    send_frame(40'hA1A2A3A4A5);
    wait_done("rsl_next_done", d0);
    total_cnt += 2;
    if (crc_data !== 40'hA1A2A3A4A5) $display("FAIL rsl_next_data: got %h expected A1A2A3A4A5", crc_data); else pass_cnt++;
    if (tx_q.size() - q0 !== 2 || tx_q[q0] !== 8'hBE || tx_q[q0 + 1] !== 8'hEF)
      $display("FAIL rsl_next_tx: got %0d bytes first=%h expected 2 bytes BE EF", tx_q.size() - q0, tx_q[q0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_byte_timeout();
    test_overrun();
    test_crc_timeout();
    test_reset_in_send_lo();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
